// File: rtl/dm_result_checker_if.sv
// Status and data-memory read-port bundle for dm_result_checker.
// Optional FirstFailIdx/FirstFailData exist only when DM_CHECK_FIRST_FAIL_EN is defined.
interface dm_result_checker_if #(
   parameter int unsigned W    = 8,
   parameter int unsigned AW   = 8,
   parameter int unsigned NCHK = 10
);
   localparam int unsigned CW = $clog2(NCHK + 1);
   localparam int unsigned IW = (NCHK > 1) ? $clog2(NCHK) : 1;

   logic            Start;
   logic [AW-1:0]   MemAddr;
   logic [W-1:0]    MemRdData;
   logic            Busy;
   logic            Done;
   logic            Pass;
   logic [NCHK-1:0] ErrMask;
   logic [CW-1:0]   ErrCount;
`ifdef DM_CHECK_FIRST_FAIL_EN
   logic [IW-1:0]   FirstFailIdx;
   logic [W-1:0]    FirstFailData;

   modport master (
      input  Start, MemRdData,
      output MemAddr, Busy, Done, Pass, ErrMask, ErrCount, FirstFailIdx, FirstFailData
   );
   modport slave (
      output Start, MemRdData,
      input  MemAddr, Busy, Done, Pass, ErrMask, ErrCount, FirstFailIdx, FirstFailData
   );
`else
   modport master (
      input  Start, MemRdData,
      output MemAddr, Busy, Done, Pass, ErrMask, ErrCount
   );
   modport slave (
      output Start, MemRdData,
      input  MemAddr, Busy, Done, Pass, ErrMask, ErrCount
   );
`endif
endinterface

// File: rtl/dm_result_checker.sv
// Reads A, B and NCHK result words from data memory, recomputes each ALU result and
// reports mismatches. Define DM_CHECK_FIRST_FAIL_EN to add first-failure capture.
module dm_result_checker #(
   parameter int unsigned W      = 8,
   parameter int unsigned AW     = 8,
   parameter int unsigned NCHK   = 10,
   parameter int unsigned BASE_A = 0,
   parameter int unsigned BASE_B = 1,
   parameter int unsigned BASE_R = 2
) (
   input logic Clk,
   input logic Reset_n,
   dm_result_checker_if.master bus
);
   localparam int unsigned CW = $clog2(NCHK + 1);
   localparam int unsigned IW = (NCHK > 1) ? $clog2(NCHK) : 1;

   typedef enum logic [2:0] {IDLE, ADDR_A, ADDR_B, CHK, DRAIN, FIN} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    a_q, a_d, b_q, b_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [NCHK-1:0] mask_q, mask_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            cmp_en;
   logic [IW-1:0]   cmp_idx;
   logic [W-1:0]    exp_val;
   logic            mism;
`ifdef DM_CHECK_FIRST_FAIL_EN
   logic [IW-1:0]   ffidx_q, ffidx_d;
   logic [W-1:0]    ffdata_q, ffdata_d;
`endif

   function automatic logic [W-1:0] alu_ref(input logic [IW-1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W-1:0] r;
      case (int'(op))
         0:       r = a + b;
         1:       r = a - b;
         2:       r = a & b;
         3:       r = a ^ b;
         4:       r = a | b;
         5:       r = ~a;
         6:       r = {{(W-1){1'b0}}, ^a};
         7:       r = a << 1;
         8:       r = a >> 1;
         9:       r = a + W'(1);
         default: r = '0;
      endcase
      return r;
   endfunction

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         addr_q   <= '0;
         mask_q   <= '0;
         cnt_q    <= '0;
`ifdef DM_CHECK_FIRST_FAIL_EN
         ffidx_q  <= '0;
         ffdata_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         addr_q   <= addr_d;
         mask_q   <= mask_d;
         cnt_q    <= cnt_d;
`ifdef DM_CHECK_FIRST_FAIL_EN
         ffidx_q  <= ffidx_d;
         ffdata_q <= ffdata_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      a_d      = a_q;
      b_d      = b_q;
      addr_d   = addr_q;
      mask_d   = mask_q;
      cnt_d    = cnt_q;
      cmp_en   = 1'b0;
      cmp_idx  = idx_q - IW'(1);
`ifdef DM_CHECK_FIRST_FAIL_EN
      ffidx_d  = ffidx_q;
      ffdata_d = ffdata_q;
`endif
      // MemAddr is registered, so it is loaded with the address for the state being entered.
      case (state_q)
         IDLE, FIN: begin
            if (bus.Start) begin
               state_d  = ADDR_A;
               addr_d   = AW'(BASE_A);
               mask_d   = '0;
               cnt_d    = '0;
`ifdef DM_CHECK_FIRST_FAIL_EN
               ffidx_d  = '0;
               ffdata_d = '0;
`endif
            end
         end
         ADDR_A: begin
            state_d = ADDR_B;
            addr_d  = AW'(BASE_B);
         end
         ADDR_B: begin
            a_d     = bus.MemRdData;
            state_d = CHK;
            idx_d   = '0;
            addr_d  = AW'(BASE_R);
         end
         CHK: begin
            if (idx_q == '0) b_d = bus.MemRdData;
            else             cmp_en = 1'b1;
            if (idx_q == IW'(NCHK - 1)) begin
               state_d = DRAIN;
            end else begin
               idx_d  = idx_q + IW'(1);
               addr_d = AW'(BASE_R) + AW'(idx_d);
            end
         end
         DRAIN: begin
            cmp_en  = 1'b1;
            cmp_idx = IW'(NCHK - 1);
            state_d = FIN;
         end
         default: state_d = IDLE;
      endcase

      exp_val = alu_ref(cmp_idx, a_q, b_q);
      mism    = cmp_en && (bus.MemRdData != exp_val);
      if (mism) begin
         mask_d[cmp_idx] = 1'b1;
         cnt_d           = cnt_q + CW'(1);
`ifdef DM_CHECK_FIRST_FAIL_EN
         if (cnt_q == '0) begin
            ffidx_d  = cmp_idx;
            ffdata_d = bus.MemRdData;
         end
`endif
      end
   end

   assign bus.MemAddr  = addr_q;
   assign bus.Busy     = (state_q == ADDR_A) || (state_q == ADDR_B) ||
                         (state_q == CHK)    || (state_q == DRAIN);
   assign bus.Done     = (state_q == FIN);
   assign bus.Pass     = (state_q == FIN) && (cnt_q == '0);
   assign bus.ErrMask  = mask_q;
   assign bus.ErrCount = cnt_q;
`ifdef DM_CHECK_FIRST_FAIL_EN
   assign bus.FirstFailIdx  = ffidx_q;
   assign bus.FirstFailData = ffdata_q;
`endif
endmodule

// File: doc/dm_result_checker.md
# dm_result_checker

Synthesizable self-checking engine for the ARMINx8 core's ALU regression program. After the core signals completion, it reads operands A and B and a block of result words from data memory. It recomputes every expected ALU result in hardware and reports a per-check error mask, an error count and pass/fail. It sits beside data memory on a dedicated read port, so silicon and emulation runs self-check without a testbench.

## Interface

Parameters:
- W, 8: data word width (2..32).
- AW, 8: data-memory address width.
- NCHK, 10: number of checks performed (1..10), op indices 0..NCHK-1.
- BASE_A, 0: address of operand A.
- BASE_B, 1: address of operand B.
- BASE_R, 2: address of first result; check i reads BASE_R+i.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- Start  in  1  begin a check run (sampled high in IDLE or FIN).
- MemAddr  out  AW  read address to data memory, registered.
- MemRdData  in  W  read data; valid the cycle after MemAddr is presented.
- Busy  out  1  run in progress.
- Done  out  1  run complete; held until next Start or reset.
- Pass  out  1  Done && ErrCount==0.
- ErrMask  out  NCHK  bit i set if check i mismatched.
- ErrCount  out  $clog2(NCHK+1)  number of mismatches.

## Operation

- Expected values, all truncated to W bits, mod 2^W. Indices 0..9 in order:
  - 0: A+B
  - 1: A−B
  - 2: A&B
  - 3: A^B
  - 4: A|B
  - 5: ~A
  - 6: ^A zero-extended
  - 7: A<<1, zero fill
  - 8: A>>1, logical
  - 9: A+1
- FSM states:
  - IDLE: Start → ADDR_A.
  - ADDR_A: MemAddr=BASE_A → ADDR_B.
  - ADDR_B: MemAddr=BASE_B; capture A → CHK.
  - CHK: MemAddr=BASE_R+i; capture B on first CHK cycle; compare data for i−1 from the second CHK cycle. After i=NCHK−1 → DRAIN.
  - DRAIN: compare last result → FIN.
  - FIN: Done=1 → on Start, clear ErrMask/ErrCount, → ADDR_A.
- Each mismatch sets its ErrMask bit and increments ErrCount in the same edge. ErrCount cannot overflow.
- Start while Busy is ignored.
- Reset mid-run aborts to IDLE; all outputs cleared.
- BASE_R+i wrapping past 2^AW−1 wraps mod 2^AW.

## Timing

- Reset values: MemAddr=0, Busy=0, Done=0, Pass=0, ErrMask=0, ErrCount=0, FSM=IDLE.
- Start sampled high at edge 0:
  - Busy=1 from cycle 1.
  - MemAddr=BASE_A in cycle 1, BASE_B in cycle 2, BASE_R+i in cycle 3+i.
  - Last compare at the edge ending cycle NCHK+3.
- Done=1 and Busy=0 from cycle NCHK+4 (cycle 14 for NCHK=10). ErrMask/ErrCount/Pass are final in that same cycle.
- Throughput: one check per cycle. No stalls; MemRdData must meet 1-cycle latency.
- Start sampled in FIN: Done drops next cycle, and the new run follows identical timing.

## Configuration

- DM_CHECK_FIRST_FAIL_EN defined: adds outputs FirstFailIdx ($clog2(NCHK) bits) and FirstFailData (W bits).
  - Captured on the first mismatch of a run only; later mismatches do not overwrite.
  - Reset to 0 and cleared on Start.
  - Value 0/0 with ErrCount==0 means no failure.
- Undefined: these ports and their registers are absent; all other behaviour is identical.

## Test plan

- W=8, NCHK=10, memory A=F0, B=CC, results BC,24,C0,3C,FC,0F,00,E0,78,F1 → Done at cycle 14, Pass=1, ErrMask=000, ErrCount=0.
- Same, but result slot 3 (addr 5)=00 → ErrMask=0x008, ErrCount=1, Pass=0. With macro: FirstFailIdx=3, FirstFailData=00.
- Slots 0 and 9 corrupted → ErrMask=0x201, ErrCount=2. With macro: FirstFailIdx=0.
- Start pulsed again at cycle 5 of a run → ignored, Done still at cycle 14. Start in FIN → ErrMask cleared, second run Done 14 cycles later.
- Reset_n low at cycle 7 → all outputs 0 immediately (async), FSM IDLE. Fresh Start gives a correct full run.
- W=16, A=FFFF, B=0001, results 0000,FFFE,0001,FFFE,FFFF,0000,0000,FFFE,7FFF,0000 → Pass=1, confirming wrap-around and reduction XOR of even parity.
